avmm_stream_uart: RTL

//  Parametrised successor to the CPU console port. Exposes two independent byte-stream FIFOs to an Avalon-MM

---
 rtl/avmm_stream_uart.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/avmm_stream_uart.sv
// Avalon-MM console port with independent TX and RX byte-stream FIFOs,
// programmable IRQ thresholds, sticky overflow flags and level readback.
module avmm_stream_uart #(
    parameter int DATA_W        = 8,
    parameter int TX_DEPTH_LOG2 = 6,
    parameter int RX_DEPTH_LOG2 = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        av_address,
    input  logic              av_chipselect,
    input  logic              av_read_n,
    input  logic              av_write_n,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic              av_irq,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int TXC_W    = TX_DEPTH_LOG2 + 1;
    localparam int RXC_W    = RX_DEPTH_LOG2 + 1;

    localparam logic [TXC_W-1:0] TX_FULL_CNT   = TXC_W'(TX_DEPTH);
    localparam logic [RXC_W-1:0] RX_FULL_CNT   = RXC_W'(RX_DEPTH);
    localparam logic [15:0]      TX_THRESH_RST = (TX_DEPTH > 8) ? 16'(TX_DEPTH - 8) : 16'd1;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_THRESH  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Registers
    logic                     r_waitrequest;
    logic [31:0]              r_readdata;
    logic                     r_ien_rx;
    logic                     r_ien_tx;
    logic                     r_roverflow;
    logic                     r_woverflow;
    logic [15:0]              r_tx_thresh;
    logic [15:0]              r_rx_thresh;

    logic [DATA_W-1:0]        r_tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] r_tx_wptr;
    logic [TX_DEPTH_LOG2-1:0] r_tx_rptr;
    logic [TXC_W-1:0]         r_tx_count;

    logic [DATA_W-1:0]        r_rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] r_rx_wptr;
    logic [RX_DEPTH_LOG2-1:0] r_rx_rptr;
    logic [RXC_W-1:0]         r_rx_count;

    // Wires
    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic        w_tx_full;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_tx_ovf;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_rx_ovf;
    logic [TXC_W-1:0] w_tx_space;
    logic [15:0] w_tx_space16;
    logic [15:0] w_rx_count16;
    logic        w_ipen_rx;
    logic        w_ipen_tx;
    logic        w_clr_rovf;
    logic        w_clr_wovf;
    logic [31:0] w_rdata;

    // Access handshake: a strobe is accepted only while waitrequest is high,
    // so every access sees exactly one wait state before readdata is valid.
    assign w_accept = av_chipselect & (~av_read_n | ~av_write_n) & r_waitrequest;
    assign w_wr     = w_accept & ~av_write_n;
    assign w_rd     = w_accept & av_write_n & ~av_read_n;

    assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
    assign tx_valid   = (r_tx_count != '0);
    assign w_tx_pop   = tx_valid & tx_ready;
    assign w_tx_push  = w_wr & (av_address == ADDR_DATA) & ~w_tx_full;
    assign w_tx_ovf   = w_wr & (av_address == ADDR_DATA) & w_tx_full;
    assign tx_data    = r_tx_mem[r_tx_rptr];
    assign w_tx_space = TX_FULL_CNT - r_tx_count;

    assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
    assign w_rx_empty = (r_rx_count == '0);
    assign rx_ready   = ~w_rx_full;
    assign w_rx_push  = rx_valid & ~w_rx_full;
    assign w_rx_ovf   = rx_valid & w_rx_full;
    assign w_rx_pop   = w_rd & (av_address == ADDR_DATA) & ~w_rx_empty;

    assign w_tx_space16 = 16'(w_tx_space);
    assign w_rx_count16 = 16'(r_rx_count);

    assign w_ipen_rx = r_ien_rx & (w_rx_count16 >= r_rx_thresh);
    assign w_ipen_tx = r_ien_tx & (w_tx_space16 >= r_tx_thresh);
    assign av_irq    = w_ipen_rx | w_ipen_tx;

    assign w_clr_rovf = w_wr & (av_address == ADDR_CONTROL) & av_writedata[13];
    assign w_clr_wovf = w_wr & (av_address == ADDR_CONTROL) & av_writedata[14];

    assign av_waitrequest = r_waitrequest;
    assign av_readdata    = r_readdata;

    always_comb begin
        w_rdata = '0;
        case (av_address)
            ADDR_DATA: begin
                w_rdata[31:16] = w_rx_count16;
                if (!w_rx_empty) begin
                    w_rdata[DATA_W-1:0] = r_rx_mem[r_rx_rptr];
                    w_rdata[15]         = 1'b1;
                end
            end
            ADDR_CONTROL: begin
                w_rdata[0]  = r_ien_rx;
                w_rdata[1]  = r_ien_tx;
                w_rdata[8]  = w_ipen_rx;
                w_rdata[9]  = w_ipen_tx;
                w_rdata[13] = r_roverflow;
                w_rdata[14] = r_woverflow;
            end
            ADDR_THRESH: w_rdata = {r_rx_thresh, r_tx_thresh};
            ADDR_STATUS: w_rdata = {w_rx_count16, w_tx_space16};
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitrequest <= 1'b1;
            r_readdata    <= '0;
        end else begin
            r_waitrequest <= ~w_accept;
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // A clear and a new overflow in the same cycle leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ien_rx    <= 1'b0;
            r_ien_tx    <= 1'b0;
            r_roverflow <= 1'b0;
            r_woverflow <= 1'b0;
            r_tx_thresh <= TX_THRESH_RST;
            r_rx_thresh <= 16'd1;
        end else begin
            r_roverflow <= (r_roverflow & ~w_clr_rovf) | w_rx_ovf;
            r_woverflow <= (r_woverflow & ~w_clr_wovf) | w_tx_ovf;
            if (w_wr && av_address == ADDR_CONTROL) begin
                r_ien_rx <= av_writedata[0];
                r_ien_tx <= av_writedata[1];
            end
            if (w_wr && av_address == ADDR_THRESH) begin
                r_tx_thresh <= (av_writedata[15:0] == 16'd0) ? 16'd1 : av_writedata[15:0];
                r_rx_thresh <= (av_writedata[31:16] == 16'd0) ? 16'd1 : av_writedata[31:16];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + 1'b1;
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= av_writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + 1'b1;
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + 1'b1;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rx_data;
        end
    end

endmodule
